// File: rtl/booth_seq_mult_ctrl.sv
// Sequential radix-4 Booth multiplier controller: one shared partial-product stage
// walks the Booth digits of y, least significant first, and accumulates the signed product.
module booth_seq_mult_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic [2:0]           digit
);

  localparam int N     = WIDTH / 2;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int XW    = WIDTH + 2;
  localparam int PW    = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [XW-1:0]      x_reg;
  logic [WIDTH:0]     y_reg;
  logic [PW-1:0]      acc;
  logic [CNT_W-1:0]   cnt;
  logic               last;
  logic [2:0]         triplet;
  logic [2:0]         booth_sel;
  logic [XW-1:0]      pp;
  logic [PW-1:0]      pp_ext;
  logic [PW-1:0]      pp_shift;
  logic [PW-1:0]      sum;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of the order the simulator evaluates processes.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  assign last = (cnt == CNT_W'(N - 1));

  // NOTE: every combinational output gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = BUSY;
      BUSY:    if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state == BUSY);
    digit     = (state == BUSY) ? booth_sel : 3'b000;
  end

  // y_reg carries an implicit y[-1]=0 in bit 0, so digit i sits at y_reg[2i+2:2i].
  always_comb begin
    triplet = 3'b000;
    for (int i = 0; i < N; i++) begin
      if (cnt == CNT_W'(i)) triplet = y_reg[2*i +: 3];
    end
  end

  always_comb begin
    case (triplet)
      3'b001, 3'b010: booth_sel = 3'b001;
      3'b011:         booth_sel = 3'b010;
      3'b100:         booth_sel = 3'b110;
      3'b101, 3'b110: booth_sel = 3'b101;
      default:        booth_sel = 3'b000;
    endcase
  end

  // WIDTH+2 bits hold +-2X for every signed operand, including -2^(WIDTH-1).
  always_comb begin
    case (booth_sel)
      3'b001:  pp = x_reg;
      3'b010:  pp = x_reg << 1;
      3'b101:  pp = -x_reg;
      3'b110:  pp = -(x_reg << 1);
      default: pp = '0;
    endcase
    pp_ext   = {{(PW - XW){pp[XW-1]}}, pp};
    pp_shift = pp_ext << {cnt, 1'b0};
    sum      = acc + pp_shift;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg   <= '0;
      y_reg   <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_reg <= {{2{x[WIDTH-1]}}, x};
            y_reg <= {y, 1'b0};
            acc   <= '0;
            cnt   <= '0;
          end
        end
        BUSY: begin
          acc <= sum;
          cnt <= cnt + 1'b1;
          if (last) product <= sum;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_mult_ctrl.sv
// Directed bench for booth_seq_mult_ctrl (WIDTH=8): digit sequence, latency,
// corner products, backpressure, back-to-back throughput and mid-operation reset.
module tb_booth_seq_mult_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  x;
  logic [7:0]  y;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;
  logic [2:0]  digit;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  int          accept_cyc[$];
  logic [15:0] prod_q[$];

  booth_seq_mult_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy),
    .digit     (digit)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && in_valid && in_ready)   accept_cyc.push_back(cyc);
    if (!rst && out_valid && out_ready) prod_q.push_back(product);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts from IDLE, accepts (a,b), checks the four BUSY cycles and the result.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                       input logic [11:0] digs, input string tag);
    x = a;
    y = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    x = 8'($urandom);
    y = 8'($urandom);
    check({tag, "_in_ready_drop"}, in_ready, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_busy%0d", tag, i), busy, 1'b1);
      check($sformatf("%s_digit%0d", tag, i), digit, digs[3*i +: 3]);
      check($sformatf("%s_ov_low%0d", tag, i), out_valid, 1'b0);
      step();
    end
    check({tag, "_out_valid"}, out_valid, 1'b1);
    check({tag, "_busy_done"}, busy, 1'b0);
    check({tag, "_digit_done"}, digit, 3'b000);
    check({tag, "_product"}, product, exp);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    step();
    check({tag, "_ov_cleared"}, out_valid, 1'b0);
    check({tag, "_in_ready_back"}, in_ready, 1'b1);
  endtask

  initial begin
    int guard;
    int n_ov;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x         = 8'h00;
    y         = 8'h00;
    step();
    step();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_product", product, 16'h0000);
    check("rst_digit", digit, 3'b000);
    rst = 1'b0;

    // 1: 3*5, digits +1,+1,0,0
    out_ready = 1'b1;
    do_op(8'd3, 8'd5, 16'h000F, 12'b000_000_001_001, "t1");
    release_out("t1");

    // 2: most negative corners
    do_op(8'h80, 8'h80, 16'h4000, 12'b110_000_000_000, "t2a");
    release_out("t2a");
    do_op(8'h80, 8'h7F, 16'hC080, 12'b010_000_000_101, "t2b");
    release_out("t2b");

    // 3: zero multiplier still takes four cycles
    do_op(8'h5A, 8'h00, 16'h0000, 12'b000_000_000_000, "t3");
    release_out("t3");

    // 4: backpressure with ignored in_valid pulses
    out_ready = 1'b0;
    do_op(8'hF9, 8'd9, 16'hFFC1, 12'b000_001_110_001, "t4");
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      x = 8'(k + 1);
      y = 8'(k + 2);
      step();
      check($sformatf("t4_hold_ov%0d", k), out_valid, 1'b1);
      check($sformatf("t4_hold_prod%0d", k), product, 16'hFFC1);
      check($sformatf("t4_hold_in_ready%0d", k), in_ready, 1'b0);
    end
    in_valid = 1'b0;
    release_out("t4");
    step();
    check("t4_no_ghost_op", busy, 1'b0);

    // 5: back-to-back with in_valid held high
    accept_cyc.delete();
    prod_q.delete();
    out_ready = 1'b1;
    x = 8'd2;
    y = 8'd3;
    in_valid = 1'b1;
    step();
    x = 8'hFF;
    y = 8'hFF;
    guard = 0;
    while (accept_cyc.size() < 2 && guard < 20) begin
      step();
      guard++;
    end
    in_valid = 1'b0;
    guard = 0;
    while (prod_q.size() < 2 && guard < 20) begin
      step();
      guard++;
    end
    check("t5_accepts", accept_cyc.size(), 2);
    check("t5_products", prod_q.size(), 2);
    if (accept_cyc.size() >= 2)
      check("t5_accept_gap", accept_cyc[1] - accept_cyc[0], 6);
    if (prod_q.size() >= 2) begin
      check("t5_prod0", prod_q[0], 16'h0006);
      check("t5_prod1", prod_q[1], 16'h0001);
    end
    step();
    check("t5_idle", in_ready, 1'b1);

    // 6: reset at the second BUSY edge discards the operation
    prod_q.delete();
    x = 8'd10;
    y = 8'd10;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("t6_busy_before_rst", busy, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_in_ready", in_ready, 1'b1);
    check("t6_out_valid", out_valid, 1'b0);
    check("t6_product", product, 16'h0000);
    check("t6_busy", busy, 1'b0);
    n_ov = 0;
    repeat (8) begin
      if (out_valid) n_ov++;
      step();
    end
    check("t6_no_emit_ov", n_ov, 0);
    check("t6_no_emit_q", prod_q.size(), 0);
    do_op(8'd4, 8'd4, 16'h0010, 12'b000_000_001_000, "t6");
    release_out("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/booth_seq_mult_ctrl.md
Name: booth_seq_mult_ctrl

Overview:
- Iterative controller that shares one radix-4 Booth partial-product stage across all digit positions of a signed multiply, instead of generating every partial product in parallel.
- Accepts one operand pair through a valid/ready handshake and walks the Booth digits of Y, one per cycle, least significant first.
- Each cycle it selects 0, ±X or ±2X, accumulates it with the correct weight, and returns the exact signed product through an output valid/ready handshake.
- Sits between a requesting datapath and the product consumer as the area-reduced alternative to the parallel PP generator plus adder tree.

Parameters:
- WIDTH, 8, operand width in bits. Must be even and ≥4. Iteration count N = WIDTH/2.

Ports:
- clk  in  1  single clock, rising-edge active
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair presented
- in_ready  out  1  controller can accept operands
- x  in  WIDTH  multiplicand, two's complement
- y  in  WIDTH  multiplier, two's complement
- out_valid  out  1  product available
- out_ready  in  1  consumer accepts product
- product  out  2*WIDTH  signed product x*y
- busy  out  1  iteration in progress
- digit  out  3  current Booth select, one-hot-ish {neg,two,one}; 000 when not BUSY

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset state (on rst sampled high at a rising edge):
  - state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, digit=000.
  - Counter and accumulator are cleared.
- rst has priority over all other inputs. Reset mid-operation discards the in-flight operation with no output.
- States:
  - IDLE: in_ready=1. On edge with in_valid=1:
    - latch x (sign-extended to WIDTH+2 bits) and {y,1'b0};
    - acc=0, cnt=0;
    - go to BUSY.
  - BUSY: in_ready=0, busy=1. Each edge:
    - form the Booth triplet t = (y[2cnt+1], y[2cnt], y[2cnt-1]), with y[-1]=0;
    - add PP(t) sign-extended to 2*WIDTH and shifted left by 2*cnt into acc, modulo 2^(2*WIDTH);
    - cnt++.
    - On the edge where cnt==N-1: load product with the final sum and go to DONE.
  - DONE: out_valid=1, busy=0, in_ready=0.
    - On edge with out_ready=1: go to IDLE with out_valid=0.
    - product keeps its value until the next result loads it.
- Booth select PP(t) (digit {neg,two,one}):
  - 000, 111 → 0 (000)
  - 001, 010 → +X (001)
  - 011 → +2X (010)
  - 100 → −2X (110)
  - 101, 110 → −X (101)
- Negation is the two's complement of the WIDTH+2-bit sign-extended X. No overflow is possible at that width.
- Latency and throughput:
  - Operands accepted at edge E0. out_valid is high after edge E_N (4 cycles for WIDTH=8).
  - With out_ready held high: back in IDLE after E_(N+1), next accept at E_(N+2).
  - Throughput is one operation per N+2 cycles.
- Stability and handshake rules:
  - product and out_valid stay stable while out_valid=1 and out_ready=0.
  - in_valid while not IDLE is ignored; there is no queuing.
  - x and y are sampled only on the accepting edge. Later changes to the inputs do not affect the operation.
- Arithmetic:
  - The result is the exact signed product for all operand pairs, including x=y=−2^(WIDTH−1).
  - Example for WIDTH=8: product = 0x4000.
- out_ready is ignored outside DONE.

Test Plan:
1. Reset, then x=3, y=5 with out_ready=1 → in_ready drops the cycle after acceptance; digit sequence is 001,001,000,000 (y=5 → digits +1,+1,0,0); out_valid rises 4 edges after acceptance; product=0x000F.
2. x=−128 (0x80), y=−128 (0x80) → product=0x4000. Also x=−128, y=127 (0x7F) → product=0xC080 (−16256).
3. x=0x5A, y=0 → all digits 000; product=0x0000; latency is still 4 cycles.
4. Backpressure: x=−7, y=9 with out_ready=0 for 3 cycles after out_valid → product holds 0xFFC1 and out_valid stays 1; in_valid pulses in that window are ignored; product is released on the first out_ready=1 edge.
5. Back-to-back: in_valid held high with pairs (2,3) then (−1,−1), out_ready=1 → products 0x0006 then 0x0001; the two accepts are exactly 6 edges apart.
6. Reset mid-op: assert rst at the 2nd BUSY edge of x=10, y=10 → the next cycle shows in_ready=1, out_valid=0, product=0, busy=0; no product is ever emitted; the next operation (4,4) yields 0x0010.
